demultiplexer_buffered: RTL and testbench
=========================================

// Module: demultiplexer_buffered
// PURPOSE
//  Registered 1-to-N demultiplexer: routes one WIDTH-bit input word to one of
//  2**SELECT_WIDTH output channels chosen by index. Each channel has a one-entry
//  holding register with valid/ready handshake. It is the write-side counterpart
//  of the generalized Multiplexer, used to fan datapath results out to consumers.
// PARAMETERS
//  WIDTH          16  data word width in bits
//  SELECT_WIDTH   3   index width; channel count N = 2**SELECT_WIDTH
// PORTS
//  clk        in   1                  single clock; all state updates on rising edge
//  reset_n    in   1                  reset, synchronous, active-low
//  in_valid   in   1                  producer presents data_in/index
//  in_ready   out  1                  block accepts word this cycle
//  data_in    in   WIDTH              word to route
//  index      in   SELECT_WIDTH       destination channel
//  out_valid  out  N                  bit i: channel i holds a word
//  out_ready  in   N                  bit i: consumer i takes word this cycle
//  data_out   out  WIDTH x N          unpacked array [N]; data_out[i] = channel i slot
//  occupancy  out  SELECT_WIDTH+1     number of channels with out_valid set
// BEHAVIOUR
//  Clocking: one clock; reset is synchronous and active-low.
//  Reset (reset_n=0 at edge): all slot valids 0, all data_out 0, occupancy 0;
//   any held or in-flight word is discarded. Reset mid-transfer has no residue.
//  Per channel i, slot state EMPTY/FULL (valid_q[i]); out_valid[i] = valid_q[i].
//  in_ready = !valid_q[index] | out_ready[index]  (combinational; bypass on drain).
//  Accept = in_valid & in_ready: at edge data_q[index] <= data_in, valid_q[index] <= 1.
//  Drain_i = valid_q[i] & out_ready[i]: at edge valid_q[i] <= 0 unless accept hits i.
//  Simultaneous accept and drain on same channel: slot stays FULL, takes new word.
//  Transitions: EMPTY -accept-> FULL; FULL -drain,no accept-> EMPTY;
//   FULL -drain+accept-> FULL(new data); FULL -no drain-> FULL (data held stable).
//  Latency: accepted word appears on data_out[index] with out_valid 1 cycle later.
//  At most one accept per cycle; any number of channels may drain in one cycle.
//  Channels are independent: a stalled channel blocks only inputs addressed to it.
//  Producer keeps data_in/index stable while in_valid & !in_ready; index ignored
//   when in_valid=0. out_ready on an EMPTY channel has no effect.
//  data_out[i] changes only on accept to i or reset; not cleared on drain.
//  occupancy registered: next = current + accept_to_empty_slot - drains_not_refilled;
//   range 0..N, width SELECT_WIDTH+1 so N fits without wrap.
//  All FULL with no out_ready: in_ready=0 for every index; no word lost or overwritten.
// TESTING
//  1 Reset: hold reset_n=0 2 cycles -> out_valid=0, occupancy=0, data_out[*]=0, in_ready=1.
//  2 Route sweep: for i=0..7 send data_in=16'hA000+i, index=i, out_ready=0 ->
//    out_valid=8'hFF, data_out[i]=16'hA000+i, occupancy=8, then in_ready=0 for all index.
//  3 Backpressure: ch3 FULL (16'h1234), out_ready[3]=0, send 16'h5678 to idx 3 ->
//    in_ready=0, data_out[3] stays 16'h1234 until out_ready[3]=1, then 5678 one cycle later.
//  4 Bypass: ch5 FULL, out_ready[5]=1 with in_valid, index=5, data 16'hBEEF same cycle ->
//    accepted, out_valid[5] stays 1, data_out[5]=16'hBEEF, occupancy unchanged.
//  5 Multi-drain: channels 0,1,2 FULL, out_ready=8'h07, no input -> out_valid=0, occupancy 3->0.
//  6 Reset mid-operation: 4 channels FULL, assert reset_n=0 for 1 cycle ->
//    out_valid=0, occupancy=0; next accept to idx 0 yields occupancy=1.

Source files
------------

// File: rtl/demultiplexer_buffered.sv
// Registered 1-to-N demultiplexer: one input word is routed by index into one of
// N single-entry channel slots, each drained independently by its own consumer.
module demultiplexer_buffered #(
  parameter int WIDTH        = 16,
  parameter int SELECT_WIDTH = 3,
  localparam int N           = 2 ** SELECT_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH-1:0]        data_in,
  input  logic [SELECT_WIDTH-1:0] index,
  output logic [N-1:0]            out_valid,
  input  logic [N-1:0]            out_ready,
  output logic [WIDTH-1:0]        data_out [N],
  output logic [SELECT_WIDTH:0]   occupancy
);

  // Handshake: a word moves on any rising edge where valid and ready are both 1.
  // The producer holds data_in/index stable while in_valid & !in_ready; consumers
  // see out_valid[i] = slot i FULL and take the word on out_valid[i] & out_ready[i].

  logic [N-1:0]          valid_q;
  logic [N-1:0]          valid_d;
  logic [N-1:0]          drain;
  logic [N-1:0]          accept_vec;
  logic                  accept;
  logic [SELECT_WIDTH:0] occ_d;

  // A full slot may still accept when its consumer drains in the same cycle.
  assign in_ready  = !valid_q[index] || out_ready[index];
  assign accept    = in_valid && in_ready;
  assign drain     = valid_q & out_ready;
  assign out_valid = valid_q;

  always_comb begin
    accept_vec = '0;
    if (accept) accept_vec[index] = 1'b1;
  end

  // Refill wins over drain on the same slot.
  assign valid_d = (valid_q & ~drain) | accept_vec;

  always_comb begin
    occ_d = '0;
    for (int i = 0; i < N; i++) begin
      occ_d = occ_d + (SELECT_WIDTH + 1)'(valid_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q   <= '0;
      occupancy <= '0;
    end else begin
      valid_q   <= valid_d;
      occupancy <= occ_d;
    end
  end

  // Data is only written on accept; drains leave the last word visible.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (!reset_n) begin
        data_out[i] <= '0;
      end else if (accept_vec[i]) begin
        data_out[i] <= data_in;
      end
    end
  end

endmodule

// File: tb/tb_demultiplexer_buffered.sv
// Directed bench for demultiplexer_buffered: routing, backpressure, drain bypass,
// multi-channel drain and reset behaviour, with hand-computed expectations.
module tb_demultiplexer_buffered;

  localparam int WIDTH        = 16;
  localparam int SELECT_WIDTH = 3;
  localparam int N            = 8;

  logic                    clk;
  logic                    reset_n;
  logic                    in_valid;
  logic                    in_ready;
  logic [WIDTH-1:0]        data_in;
  logic [SELECT_WIDTH-1:0] index;
  logic [N-1:0]            out_valid;
  logic [N-1:0]            out_ready;
  logic [WIDTH-1:0]        data_out [N];
  logic [SELECT_WIDTH:0]   occupancy;

  int checks;
  int errors;
  logic [WIDTH-1:0] exp_q[$];

  demultiplexer_buffered #(
    .WIDTH(WIDTH),
    .SELECT_WIDTH(SELECT_WIDTH)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .data_in(data_in),
    .index(index),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .data_out(data_out),
    .occupancy(occupancy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = '0;
    data_in   = '0;
    index     = '0;
    repeat (cycles) tick();
    reset_n = 1'b1;
  endtask

  // driver: present one word for one cycle, expecting it to be accepted
  task automatic send(input logic [SELECT_WIDTH-1:0] idx, input logic [WIDTH-1:0] d);
    in_valid = 1'b1;
    index    = idx;
    data_in  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = '0;
    data_in   = '0;
    index     = '0;
    repeat (2) tick();
    checks++;
    if (out_valid !== 8'h00) begin
      errors++; $display("FAIL reset_out_valid: got %h want %h", out_valid, 8'h00);
    end
    checks++;
    if (occupancy !== 4'd0) begin
      errors++; $display("FAIL reset_occupancy: got %0d want 0", occupancy);
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (data_out[i] !== 16'h0000) begin
        errors++; $display("FAIL reset_data_out[%0d]: got %h want 0000", i, data_out[i]);
      end
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_route_sweep();
    logic [WIDTH-1:0] exp_word;
    do_reset(1);
    for (int i = 0; i < N; i++) begin
      in_valid = 1'b1;
      index    = SELECT_WIDTH'(i);
      data_in  = 16'hA000 + 16'(i);
      exp_q.push_back(16'hA000 + 16'(i));
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++; $display("FAIL sweep_in_ready[%0d]: got %b want 1", i, in_ready);
      end
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 8'hFF) begin
      errors++; $display("FAIL sweep_out_valid: got %h want ff", out_valid);
    end
    checks++;
    if (occupancy !== 4'd8) begin
      errors++; $display("FAIL sweep_occupancy: got %0d want 8", occupancy);
    end
    for (int i = 0; i < N; i++) begin
      exp_word = exp_q.pop_front();
      checks++;
      if (data_out[i] !== exp_word) begin
        errors++; $display("FAIL sweep_data_out[%0d]: got %h want %h", i, data_out[i], exp_word);
      end
    end
    // every slot full and nobody draining: nothing can enter, nothing is overwritten
    for (int i = 0; i < N; i++) begin
      in_valid = 1'b1;
      index    = SELECT_WIDTH'(i);
      data_in  = 16'hDEAD;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
        errors++; $display("FAIL full_in_ready[%0d]: got %b want 0", i, in_ready);
      end
      tick();
      checks++;
      if (data_out[i] !== 16'hA000 + 16'(i)) begin
        errors++; $display("FAIL full_hold[%0d]: got %h want %h", i, data_out[i], 16'hA000 + 16'(i));
      end
    end
    in_valid = 1'b0;
    checks++;
    if (occupancy !== 4'd8) begin
      errors++; $display("FAIL full_occupancy: got %0d want 8", occupancy);
    end
  endtask

  task automatic test_backpressure();
    do_reset(1);
    send(3'd3, 16'h1234);
    in_valid  = 1'b1;
    index     = 3'd3;
    data_in   = 16'h5678;
    out_ready = '0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
        errors++; $display("FAIL bp_in_ready[%0d]: got %b want 0", c, in_ready);
      end
      tick();
      checks++;
      if (data_out[3] !== 16'h1234) begin
        errors++; $display("FAIL bp_hold[%0d]: got %h want 1234", c, data_out[3]);
      end
    end
    out_ready = 8'h08;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release_ready: got %b want 1", in_ready);
    end
    tick();
    in_valid  = 1'b0;
    out_ready = '0;
    checks++;
    if (data_out[3] !== 16'h5678) begin
      errors++; $display("FAIL bp_new_data: got %h want 5678", data_out[3]);
    end
    checks++;
    if (out_valid !== 8'h08) begin
      errors++; $display("FAIL bp_out_valid: got %h want 08", out_valid);
    end
    checks++;
    if (occupancy !== 4'd1) begin
      errors++; $display("FAIL bp_occupancy: got %0d want 1", occupancy);
    end
  endtask

  task automatic test_bypass();
    do_reset(1);
    send(3'd5, 16'h1111);
    send(3'd2, 16'h2222);
    checks++;
    if (occupancy !== 4'd2) begin
      errors++; $display("FAIL bypass_pre_occupancy: got %0d want 2", occupancy);
    end
    in_valid  = 1'b1;
    index     = 3'd5;
    data_in   = 16'hBEEF;
    out_ready = 8'h20;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL bypass_in_ready: got %b want 1", in_ready);
    end
    tick();
    in_valid  = 1'b0;
    out_ready = '0;
    checks++;
    if (out_valid !== 8'h24) begin
      errors++; $display("FAIL bypass_out_valid: got %h want 24", out_valid);
    end
    checks++;
    if (data_out[5] !== 16'hBEEF) begin
      errors++; $display("FAIL bypass_data: got %h want beef", data_out[5]);
    end
    checks++;
    if (occupancy !== 4'd2) begin
      errors++; $display("FAIL bypass_occupancy: got %0d want 2", occupancy);
    end
  endtask

  task automatic test_multi_drain();
    do_reset(1);
    send(3'd0, 16'hC000);
    send(3'd1, 16'hC001);
    send(3'd2, 16'hC002);
    checks++;
    if (occupancy !== 4'd3) begin
      errors++; $display("FAIL drain_pre_occupancy: got %0d want 3", occupancy);
    end
    out_ready = 8'h07;
    tick();
    out_ready = '0;
    checks++;
    if (out_valid !== 8'h00) begin
      errors++; $display("FAIL drain_out_valid: got %h want 00", out_valid);
    end
    checks++;
    if (occupancy !== 4'd0) begin
      errors++; $display("FAIL drain_occupancy: got %0d want 0", occupancy);
    end
    checks++;
    if (data_out[1] !== 16'hC001) begin
      errors++; $display("FAIL drain_data_kept: got %h want c001", data_out[1]);
    end
    // draining an empty slot is a no-op
    out_ready = 8'hFF;
    tick();
    out_ready = '0;
    checks++;
    if (occupancy !== 4'd0) begin
      errors++; $display("FAIL drain_empty_occupancy: got %0d want 0", occupancy);
    end
  endtask

  task automatic test_reset_mid();
    do_reset(1);
    for (int i = 0; i < 4; i++) send(SELECT_WIDTH'(i), 16'h4000 + 16'(i));
    checks++;
    if (occupancy !== 4'd4) begin
      errors++; $display("FAIL mid_pre_occupancy: got %0d want 4", occupancy);
    end
    reset_n  = 1'b0;
    in_valid = 1'b1;
    index    = 3'd4;
    data_in  = 16'h9999;
    tick();
    reset_n  = 1'b1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 8'h00) begin
      errors++; $display("FAIL mid_out_valid: got %h want 00", out_valid);
    end
    checks++;
    if (occupancy !== 4'd0) begin
      errors++; $display("FAIL mid_occupancy: got %0d want 0", occupancy);
    end
    checks++;
    if (data_out[0] !== 16'h0000 || data_out[4] !== 16'h0000) begin
      errors++; $display("FAIL mid_data_cleared: got %h/%h want 0000/0000", data_out[0], data_out[4]);
    end
    send(3'd0, 16'h7777);
    checks++;
    if (occupancy !== 4'd1) begin
      errors++; $display("FAIL mid_after_occupancy: got %0d want 1", occupancy);
    end
    checks++;
    if (out_valid !== 8'h01 || data_out[0] !== 16'h7777) begin
      errors++; $display("FAIL mid_after_word: got %h/%h want 01/7777", out_valid, data_out[0]);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_route_sweep();
    test_backpressure();
    test_bypass();
    test_multi_drain();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
